// File: rtl/xillybus_stream_pkg.sv
// Shared types and constants for the Xillybus host-to-FPGA stream consumer.
package xillybus_stream_pkg;

  localparam int unsigned STREAM_DW = 32;
  localparam int unsigned FRAMES_CW = 16;
  localparam int unsigned OVF_CW    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/xillybus_sync_ram.sv
// Register-array buffer: one synchronous write port, one combinational read port.
module xillybus_sync_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/xillybus_wr_stream_fifo.sv
// Buffers the Xillybus wr_0 write stream and re-emits it as a framed valid/ready stream.
// Optional dropped-write counter port enabled by defining WR_STREAM_OVERFLOW_CNT_EN.
module xillybus_wr_stream_fifo
  import xillybus_stream_pkg::*;
#(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned FRAME_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic                 bus_clk_w,
  input  logic                 bus_reset_n_w,
  input  logic [STREAM_DW-1:0] user_w_wr_0_data_w,
  input  logic                 user_w_wr_0_wren_w,
  input  logic                 user_w_wr_0_open_w,
  output logic                 user_w_wr_0_full_w,
  output logic [STREAM_DW-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic [FRAMES_CW-1:0] frames_done,
  output logic [AW:0]          fill_level
`ifdef WR_STREAM_OVERFLOW_CNT_EN
  ,
  output logic [OVF_CW-1:0]    overflow_cnt
`endif
);

  localparam int unsigned BW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_WORDS - 1);

  state_t               state, state_nxt;
  logic [AW-1:0]        wr_ptr, wr_ptr_nxt;
  logic [AW-1:0]        rd_ptr, rd_ptr_nxt;
  logic [AW:0]          count, count_nxt;
  logic [BW-1:0]        beat_cnt, beat_cnt_nxt;
  logic [FRAMES_CW-1:0] frames_nxt;
  logic                 full_nxt;
  logic                 wr_en_c;
  logic                 accept_c;
  logic [STREAM_DW-1:0] ram_rdata;

  // Writes are accepted only while running and not back-pressured.
  assign wr_en_c  = (state == ST_RUN) && user_w_wr_0_wren_w && !user_w_wr_0_full_w;
  assign m_tvalid = (state == ST_RUN) && (count != '0);
  assign m_tlast  = m_tvalid && (beat_cnt == LAST_BEAT);
  assign m_tdata  = m_tvalid ? ram_rdata : '0;
  assign accept_c = m_tvalid && m_tready;
  assign fill_level = count;

  xillybus_sync_ram #(
    .DEPTH (DEPTH),
    .WIDTH (STREAM_DW)
  ) u_ram (
    .clk   (bus_clk_w),
    .we    (wr_en_c),
    .waddr (wr_ptr),
    .wdata (user_w_wr_0_data_w),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // Next-state, pointer, occupancy and framing logic; closing the file discards everything buffered.
  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    count_nxt    = count;
    beat_cnt_nxt = beat_cnt;
    frames_nxt   = frames_done;
    full_nxt     = 1'b1;

    case (state)
      ST_IDLE: begin
        if (user_w_wr_0_open_w) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept_c && m_tlast) begin
          frames_nxt = frames_done + FRAMES_CW'(1);
        end
        if (!user_w_wr_0_open_w) begin
          state_nxt    = ST_FLUSH;
          wr_ptr_nxt   = '0;
          rd_ptr_nxt   = '0;
          count_nxt    = '0;
          beat_cnt_nxt = '0;
        end else begin
          if (wr_en_c) begin
            wr_ptr_nxt = wr_ptr + AW'(1);
          end
          if (accept_c) begin
            rd_ptr_nxt   = rd_ptr + AW'(1);
            beat_cnt_nxt = m_tlast ? '0 : beat_cnt + BW'(1);
          end
          count_nxt = count + (AW+1)'(wr_en_c) - (AW+1)'(accept_c);
        end
      end
      ST_FLUSH: begin
        state_nxt    = ST_IDLE;
        wr_ptr_nxt   = '0;
        rd_ptr_nxt   = '0;
        count_nxt    = '0;
        beat_cnt_nxt = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    full_nxt = (state_nxt != ST_RUN) || (count_nxt == FULL_CNT);
  end

  always_ff @(posedge bus_clk_w) begin
    if (!bus_reset_n_w) begin
      state              <= ST_IDLE;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      beat_cnt           <= '0;
      frames_done        <= '0;
      user_w_wr_0_full_w <= 1'b1;
    end else begin
      state              <= state_nxt;
      wr_ptr             <= wr_ptr_nxt;
      rd_ptr             <= rd_ptr_nxt;
      count              <= count_nxt;
      beat_cnt           <= beat_cnt_nxt;
      frames_done        <= frames_nxt;
      user_w_wr_0_full_w <= full_nxt;
    end
  end

`ifdef WR_STREAM_OVERFLOW_CNT_EN
  logic [OVF_CW-1:0] ovf_nxt;

  // Saturating count of writes rejected by back-pressure while running.
  always_comb begin
    ovf_nxt = overflow_cnt;
    if ((state == ST_FLUSH) || ((state == ST_RUN) && !user_w_wr_0_open_w)) begin
      ovf_nxt = '0;
    end else if ((state == ST_RUN) && user_w_wr_0_wren_w && user_w_wr_0_full_w &&
                 (overflow_cnt != '1)) begin
      ovf_nxt = overflow_cnt + OVF_CW'(1);
    end
  end

  always_ff @(posedge bus_clk_w) begin
    if (!bus_reset_n_w) begin
      overflow_cnt <= '0;
    end else begin
      overflow_cnt <= ovf_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_xillybus_wr_stream_fifo.sv
// Scoreboard bench for xillybus_wr_stream_fifo (DEPTH=4, FRAME_WORDS=4).
module tb_xillybus_wr_stream_fifo;

  localparam int DEPTH = 4;
  localparam int FW    = 4;
  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_FLUSH = 2;

  typedef struct {
    logic [31:0] d;
    logic        last;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] wdata;
  logic        wren;
  logic        open;
  logic        full;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [15:0] frames;
  logic [2:0]  fill;
`ifdef WR_STREAM_OVERFLOW_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  int    n_total;
  int    n_pass;
  beat_t exp_q[$];
  int    ph;
  int    m_cnt;
  int    wr_seq;
  int    m_frames;
  int    m_ovf;

  xillybus_wr_stream_fifo #(
    .DEPTH       (DEPTH),
    .FRAME_WORDS (FW)
  ) dut (
    .bus_clk_w          (clk),
    .bus_reset_n_w      (rst_n),
    .user_w_wr_0_data_w (wdata),
    .user_w_wr_0_wren_w (wren),
    .user_w_wr_0_open_w (open),
    .user_w_wr_0_full_w (full),
    .m_tdata            (tdata),
    .m_tvalid           (tvalid),
    .m_tready           (tready),
    .m_tlast            (tlast),
    .frames_done        (frames),
    .fill_level         (fill)
`ifdef WR_STREAM_OVERFLOW_CNT_EN
    ,
    .overflow_cnt       (ovf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Monitor: every accepted beat must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && tvalid && tready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_beat: got %0h expected none at %0t", tdata, $time);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        chk("tdata", tdata, b.d);
        chk("tlast", 32'(tlast), 32'(b.last));
        if (b.last) m_frames++;
      end
    end
  end

  // One clock of stimulus; the model advances by the stream rules, then registered outputs are checked.
  task automatic step(input logic wr, input logic [31:0] d, input logic rdy, input logic op);
    bit w_ok;
    bit r_ok;
    wren   = wr;
    wdata  = d;
    tready = rdy;
    open   = op;
    w_ok = (ph == PH_RUN) && wr && (m_cnt < DEPTH);
    r_ok = (ph == PH_RUN) && rdy && (m_cnt > 0);
    if (w_ok) begin
      exp_q.push_back('{d, (wr_seq % FW) == FW - 1});
      wr_seq++;
    end
    if ((ph == PH_RUN) && wr && (m_cnt == DEPTH) && (m_ovf != 16'hFFFF)) m_ovf++;
    @(posedge clk);
    m_cnt = m_cnt + int'(w_ok) - int'(r_ok);
    case (ph)
      PH_IDLE: if (op) ph = PH_RUN;
      PH_RUN: if (!op) begin
        ph     = PH_FLUSH;
        m_cnt  = 0;
        wr_seq = 0;
        m_ovf  = 0;
        exp_q.delete();
      end
      default: begin
        ph    = PH_IDLE;
        m_ovf = 0;
      end
    endcase
    #1;
    chk("fill_level", 32'(fill), 32'(m_cnt));
    chk("full", 32'(full), 32'((ph != PH_RUN) || (m_cnt == DEPTH)));
    chk("frames_done", 32'(frames), 32'(m_frames));
`ifdef WR_STREAM_OVERFLOW_CNT_EN
    chk("overflow_cnt", 32'(ovf_cnt), 32'(m_ovf));
`endif
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    open   = 1'b0;
    wren   = 1'b0;
    tready = 1'b0;
    wdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    ph       = PH_IDLE;
    m_cnt    = 0;
    wr_seq   = 0;
    m_frames = 0;
    m_ovf    = 0;
    chk("rst_full", 32'(full), 32'd1);
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tlast", 32'(tlast), 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_frames", 32'(frames), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a_words [3];
    n_total = 0;
    n_pass  = 0;
    a_words[0] = 32'hA1;
    a_words[1] = 32'hA2;
    a_words[2] = 32'hA3;

    // Basic fall-through with three words.
    do_reset();
    step(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, a_words[i], 1'b1, 1'b1);
      chk("ft_tvalid", 32'(tvalid), 32'd1);
      chk("ft_tdata", tdata, a_words[i]);
    end
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("ft_fill_zero", 32'(fill), 32'd0);
    chk("ft_drained", 32'(exp_q.size()), 32'd0);

    // Overfill with no readiness: 4 stored, 2 dropped.
    do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b1);
      if (i == 3) chk("of_full_after4", 32'(full), 32'd1);
    end
    chk("of_fill4", 32'(fill), 32'd4);
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("of_drained", 32'(exp_q.size()), 32'd0);
    chk("of_fill0", 32'(fill), 32'd0);

    // Eight continuous beats make two frames.
    do_reset();
    step(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 32'hC0 + 32'(i), 1'b1, 1'b1);
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("fr_frames2", 32'(frames), 32'd2);

    // Close mid-frame, then reopen and finish a fresh frame.
    do_reset();
    step(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 32'hD0 + 32'(i), 1'b1, 1'b1);
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("cl_tvalid", 32'(tvalid), 32'd0);
    chk("cl_fill", 32'(fill), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'hE0 + 32'(i), 1'b1, 1'b1);
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("cl_frames2", 32'(frames), 32'd2);

    // Accept and write together at full: write dropped.
    do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'hF0 + 32'(i), 1'b0, 1'b1);
    step(1'b1, 32'hEE, 1'b1, 1'b1);
    chk("sim_fill3", 32'(fill), 32'd3);
    chk("sim_full0", 32'(full), 32'd0);
    repeat (4) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("sim_drained", 32'(exp_q.size()), 32'd0);

`ifdef WR_STREAM_OVERFLOW_CNT_EN
    // Dropped writes counted, then cleared by close.
    do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h10 + 32'(i), 1'b0, 1'b1);
    repeat (10) step(1'b1, 32'h99, 1'b0, 1'b1);
    chk("ovf_10", 32'(ovf_cnt), 32'd10);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("ovf_cleared", 32'(ovf_cnt), 32'd0);
`endif

    // Randomised traffic with occasional close/reopen.
    do_reset();
    begin
      logic op;
      op = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 149) == 0) op = !op;
        step($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 3) != 0, op);
      end
    end
    repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1);
    chk("rnd_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
